// File: rtl/micro_itlb_pkg.sv
// Shared types and field widths for the micro ITLB and its entry slices.
package micro_itlb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WALK   = 2'd2
  } state_e;

  localparam int TAG_W   = 20;
  localparam int MASK_W  = 16;
  localparam int PPAGE_W = 20;

  localparam logic [2:0] UNCACHED = 3'b010;

  // Clears the page-number bits covered by a page mask (mask spans bits 27:12).
  function automatic logic [19:0] mask_page(input logic [19:0] page, input logic [MASK_W-1:0] mask);
    return page & ~{4'h0, mask};
  endfunction

endpackage

// File: rtl/micro_itlb_entry.sv
// One micro-ITLB entry: stores a translation and matches it against vaddr.
// Hit/paddr are combinational from the stored fields; writes and flush land on the next edge.
module micro_itlb_entry
  import micro_itlb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [MASK_W-1:0]  wr_mask,
  input  logic [PPAGE_W-1:0] wr_ppage,
  input  logic [2:0]         wr_cache,
  input  logic               wr_io,
  input  logic [31:0]        vaddr,
  output logic               hit,
  output logic [31:0]        paddr,
  output logic [2:0]         cache,
  output logic               io
);

  logic               valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [MASK_W-1:0]  mask_q, mask_d;
  logic [PPAGE_W-1:0] ppage_q, ppage_d;
  logic [2:0]         cache_q, cache_d;
  logic               io_q, io_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    mask_d  = mask_q;
    ppage_d = ppage_q;
    cache_d = cache_q;
    io_d    = io_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
      tag_d   = wr_tag;
      mask_d  = wr_mask;
      ppage_d = wr_ppage;
      cache_d = wr_cache;
      io_d    = wr_io;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      mask_q  <= '0;
      ppage_q <= '0;
      cache_q <= UNCACHED;
      io_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      mask_q  <= mask_d;
      ppage_q <= ppage_d;
      cache_q <= cache_d;
      io_q    <= io_d;
    end
  end

  assign hit   = valid_q && (mask_page(vaddr[31:12], mask_q) == tag_q);
  // Masked page bits pass through from the virtual address.
  assign paddr = {ppage_q[19:16], (ppage_q[15:0] & ~mask_q) | (vaddr[27:12] & mask_q), vaddr[11:0]};
  assign cache = cache_q;
  assign io    = io_q;

endmodule

// File: rtl/micro_itlb.sv
// Fully-associative fetch translation cache in front of the main TLB; hit latency 1, miss latency 2.
// ready drops while a miss walks; responses are pulses the consumer always takes. Optional MICRO_ITLB_STATS_EN adds hit/miss counters.
module micro_itlb
  import micro_itlb_pkg::*;
#(
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] vaddr,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic [2:0]  resp_cache,
  output logic        resp_io,
  output logic        resp_miss,
  output logic        resp_invalid,
  input  logic        flush,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_invalid,
  input  logic [2:0]  tlb_cache,
  input  logic        tlb_io,
  input  logic [15:0] tlb_pagemask
`ifdef MICRO_ITLB_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_e             state_q, state_d;
  logic [31:0]        vreg_q, vreg_d;
  logic [IDX_W-1:0]   rptr_q, rptr_d;

  logic [ENTRIES-1:0] hit_vec;
  logic [31:0]        ent_paddr [ENTRIES];
  logic [2:0]         ent_cache [ENTRIES];
  logic               ent_io    [ENTRIES];

  logic               sel_hit;
  logic [31:0]        sel_paddr;
  logic [2:0]         sel_cache;
  logic               sel_io;
  logic               lookup_hit;
  logic               refill;
  logic [TAG_W-1:0]   wr_tag;
  logic [PPAGE_W-1:0] wr_ppage;

  assign lookup_hit = (state_q == ST_LOOKUP) && sel_hit && !flush;
  assign refill     = (state_q == ST_WALK) && !tlb_miss && !tlb_invalid && !flush;
  assign wr_tag     = mask_page(vreg_q[31:12], tlb_pagemask);
  assign wr_ppage   = mask_page(tlb_paddr[31:12], tlb_pagemask);
  assign tlb_vaddr  = vreg_q;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    micro_itlb_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .wr_en    (refill && (rptr_q == IDX_W'(i))),
      .wr_tag   (wr_tag),
      .wr_mask  (tlb_pagemask),
      .wr_ppage (wr_ppage),
      .wr_cache (tlb_cache),
      .wr_io    (tlb_io),
      .vaddr    (vreg_q),
      .hit      (hit_vec[i]),
      .paddr    (ent_paddr[i]),
      .cache    (ent_cache[i]),
      .io       (ent_io[i])
    );
  end

  // Walk from the top so the lowest matching index ends up selected.
  always_comb begin
    sel_hit   = 1'b0;
    sel_paddr = '0;
    sel_cache = '0;
    sel_io    = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit   = 1'b1;
        sel_paddr = ent_paddr[i];
        sel_cache = ent_cache[i];
        sel_io    = ent_io[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    vreg_d       = vreg_q;
    rptr_d       = rptr_q;
    ready        = 1'b0;
    resp_valid   = 1'b0;
    resp_paddr   = '0;
    resp_cache   = '0;
    resp_io      = 1'b0;
    resp_miss    = 1'b0;
    resp_invalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          vreg_d  = vaddr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          resp_valid = 1'b1;
          resp_paddr = sel_paddr;
          resp_cache = sel_cache;
          resp_io    = sel_io;
          ready      = 1'b1;
          if (req) begin
            vreg_d  = vaddr;
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        resp_valid   = 1'b1;
        resp_paddr   = tlb_paddr;
        resp_cache   = tlb_cache;
        resp_io      = tlb_io;
        resp_miss    = tlb_miss;
        resp_invalid = tlb_invalid;
        if (refill) begin
          rptr_d = rptr_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      vreg_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      vreg_q  <= vreg_d;
      rptr_q  <= rptr_d;
    end
  end

`ifdef MICRO_ITLB_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if ((state_q == ST_LOOKUP) && !lookup_hit && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_micro_itlb.sv
// Directed bench for micro_itlb: stimulus queues expected responses, a negedge monitor checks them.
module tb_micro_itlb;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] vaddr;
  logic        ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_cache;
  logic        resp_io;
  logic        resp_miss;
  logic        resp_invalid;
  logic        flush;
  logic [31:0] tlb_vaddr;
  logic [31:0] tlb_paddr;
  logic        tlb_miss;
  logic        tlb_invalid;
  logic [2:0]  tlb_cache;
  logic        tlb_io;
  logic [15:0] tlb_pagemask;
`ifdef MICRO_ITLB_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  micro_itlb #(.ENTRIES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .vaddr        (vaddr),
    .ready        (ready),
    .resp_valid   (resp_valid),
    .resp_paddr   (resp_paddr),
    .resp_cache   (resp_cache),
    .resp_io      (resp_io),
    .resp_miss    (resp_miss),
    .resp_invalid (resp_invalid),
    .flush        (flush),
    .tlb_vaddr    (tlb_vaddr),
    .tlb_paddr    (tlb_paddr),
    .tlb_miss     (tlb_miss),
    .tlb_invalid  (tlb_invalid),
    .tlb_cache    (tlb_cache),
    .tlb_io       (tlb_io),
    .tlb_pagemask (tlb_pagemask)
`ifdef MICRO_ITLB_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] paddr;
    logic [2:0]  cache;
    logic        io;
    logic        miss;
    logic        inv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_resp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: every cycle either matches the queue head or must be quiet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_quiet", {63'd0, resp_valid}, 64'd0);
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got paddr=%h at cycle %0d, expected no response", resp_paddr, cyc);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          n_resp++;
          if (cyc != e.cyc || resp_paddr !== e.paddr || resp_cache !== e.cache ||
              resp_io !== e.io || resp_miss !== e.miss || resp_invalid !== e.inv) begin
            n_bad++;
            $display("FAIL resp%0d: got cyc=%0d paddr=%h cache=%0d io=%0b miss=%0b inv=%0b, expected cyc=%0d paddr=%h cache=%0d io=%0b miss=%0b inv=%0b",
                     n_resp, cyc, resp_paddr, resp_cache, resp_io, resp_miss, resp_invalid,
                     e.cyc, e.paddr, e.cache, e.io, e.miss, e.inv);
          end
        end
      end else begin
        check("idle_zero", {27'd0, resp_paddr, resp_cache, resp_io, resp_miss, resp_invalid}, 64'd0);
      end
    end
  end

  task automatic set_tlb(input logic [31:0] pa, input logic [15:0] pm, input logic [2:0] ca,
                         input logic i_o, input logic mi, input logic inv);
    tlb_paddr    = pa;
    tlb_pagemask = pm;
    tlb_cache    = ca;
    tlb_io       = i_o;
    tlb_miss     = mi;
    tlb_invalid  = inv;
  endtask

  // lat: 1 = hit, 2 = walk. fl: 0 none, 1 flush in LOOKUP cycle, 2 flush in WALK cycle.
  task automatic issue(input logic [31:0] va, input logic [31:0] pa, input logic [2:0] ca,
                       input logic i_o, input logic mi, input logic inv, input int lat, input int fl);
    exp_t e;
    int   waited;
    req   = 1'b1;
    vaddr = va;
    @(posedge clk); #1;
    req     = 1'b0;
    e.cyc   = 32'(cyc + lat - 1);
    e.paddr = pa;
    e.cache = ca;
    e.io    = i_o;
    e.miss  = mi;
    e.inv   = inv;
    exp_q.push_back(e);
    waited = 0;
    if (fl == 1) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush  = 1'b0;
      waited = 1;
    end else if (fl == 2) begin
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush  = 1'b0;
      waited = 2;
    end
    if (lat == 2) begin
      repeat (2 - waited) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    req   = 1'b0;
    vaddr = '0;
    flush = 1'b0;
    set_tlb(32'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_ready", {63'd0, ready}, 64'd1);
    check("reset_vreg", {32'd0, tlb_vaddr}, 64'd0);
    @(posedge clk); #1;

    // Cold miss fills entry 0, then back-to-back hits with the main TLB showing junk.
    set_tlb(32'h01801234, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00401234, 32'h01801234, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    set_tlb(32'hDEADB000, 16'h0, 3'd5, 1'b1, 1'b0, 1'b0);
    issue(32'h00401ABC, 32'h01801ABC, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);
    issue(32'h00401000, 32'h01801000, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);
    issue(32'h00401FFF, 32'h01801FFF, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);

    // Unmapped segments: full page mask, offset bits 27:12 pass through.
    set_tlb(32'h00001000, 16'hFFFF, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(32'h80001000, 32'h00001000, 3'd2, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h8FFFF000, 32'h0FFFF000, 3'd2, 1'b0, 1'b0, 1'b0, 1, 0);
    set_tlb(32'h00000000, 16'hFFFF, 3'd2, 1'b1, 1'b0, 1'b0);
    issue(32'hA0000000, 32'h00000000, 3'd2, 1'b1, 1'b0, 1'b0, 2, 0);
    issue(32'hA0000040, 32'h00000040, 3'd2, 1'b1, 1'b0, 1'b0, 1, 0);

    // Exceptions are reported but never cached.
    set_tlb(32'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    issue(32'h00C00000, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 2, 0);
    issue(32'h00C00000, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 2, 0);
    set_tlb(32'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    issue(32'h00C00000, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 2, 0);

    // Wrap: rptr=3; fills land in entries 3, 0, 1, 2 evicting older pages.
    set_tlb(32'h00020000, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00010000, 32'h00020000, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    set_tlb(32'h00021000, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00011000, 32'h00021000, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    set_tlb(32'h01801234, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00401234, 32'h01801234, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    set_tlb(32'h0FFFF000, 16'hFFFF, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(32'h8FFFF000, 32'h0FFFF000, 3'd2, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h00010444, 32'h00020444, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);

    // Flush during WALK: response still delivered, nothing cached, everything cleared.
    set_tlb(32'h03000000, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00700000, 32'h03000000, 3'd3, 1'b0, 1'b0, 1'b0, 2, 2);
    set_tlb(32'h00020444, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00010444, 32'h00020444, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    set_tlb(32'h03000000, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00700000, 32'h03000000, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h00700ABC, 32'h03000ABC, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);

    // Flush in LOOKUP forces a walk even though the page is resident; the walk refills.
    set_tlb(32'h03000ABC, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00700ABC, 32'h03000ABC, 3'd3, 1'b0, 1'b0, 1'b0, 2, 1);
    set_tlb(32'h00020444, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00010444, 32'h00020444, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h00700000, 32'h03000000, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);

    // Reset in the LOOKUP cycle of a would-be hit: no response, entries lost.
    req   = 1'b1;
    vaddr = 32'h00700000;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {63'd0, ready}, 64'd1);
    check("post_reset_vreg", {32'd0, tlb_vaddr}, 64'd0);
    @(posedge clk); #1;
    set_tlb(32'h03000000, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(32'h00700000, 32'h03000000, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);
    issue(32'h00700FFC, 32'h03000FFC, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_responses", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/micro_itlb.md
Name: micro_itlb

Overview:
- Small fully-associative instruction-side translation cache between the fetch unit and the main TLB's instruction port.
- Fetch hits are served from local entries with a registered response. Misses walk the main TLB's combinational instruction lookup for one cycle, then refill a local entry.
- Unmapped segments are cached the same way; the main TLB reports them as 16'hffff page masks.
- Flushed by COP0 on any TLB write, EntryHi ASID write, or Status.ERL change.

Parameters:
- ENTRIES, 4, number of entries; power of two, 2..8.
- IDX_W, $clog2(ENTRIES), entry index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  1  fetch translation request
- vaddr  in  32  fetch virtual address
- ready  out  1  request accepted this cycle when req&ready
- resp_valid  out  1  one-cycle response pulse; consumer always accepts
- resp_paddr  out  32  physical address
- resp_cache  out  3  cache attribute
- resp_io  out  1  I/O region (vaddr[31:29]==3'b101)
- resp_miss  out  1  TLB refill exception
- resp_invalid  out  1  TLB invalid exception
- flush  in  1  clear all entries
- tlb_vaddr  out  32  address driven to main TLB instruction port
- tlb_paddr  in  32  main TLB pAddrI
- tlb_miss  in  1  main TLB missI
- tlb_invalid  in  1  main TLB invalidI
- tlb_cache  in  3  main TLB cacheI
- tlb_io  in  1  main TLB IOAddrI
- tlb_pagemask  in  16  main TLB pageMaskI_out

Behaviour:
- Entry fields: valid, tag[19:0] (vaddr[31:12] with masked bits zeroed), mask[15:0] (covers vaddr[27:12]), ppage[19:0], cache[2:0], io.
- Hit rule for entry e: valid && ((vaddr[31:12] & ~{4'h0,mask}) == tag).
- Hit address: paddr[31:28] = ppage[19:16]; paddr[27:12] = (ppage[15:0] & ~mask) | (vaddr[27:12] & mask); paddr[11:0] = vaddr[11:0].
- Multiple hits cannot occur: refill only follows a miss, and flush clears everything. Lowest index wins if they ever do.
- FSM IDLE / LOOKUP / WALK; reset state IDLE.
- IDLE: ready=1; req captures vaddr into vreg, go to LOOKUP.
- LOOKUP on hit: resp_valid=1 with the entry's data and miss/invalid=0, same cycle. ready=1; a new req goes to LOOKUP, otherwise IDLE. Back-to-back hits give one response per cycle, latency 1.
- LOOKUP on miss: ready=0, go to WALK.
- WALK: tlb_vaddr=vreg (tlb_vaddr=vreg in all states). Sample the tlb_* inputs and set resp_valid=1 this cycle with resp_paddr=tlb_paddr, cache, io, miss, invalid.
- WALK refill: if !tlb_miss && !tlb_invalid && !flush, write entry[rptr] with tag = vreg[31:12] & ~{4'h0,tlb_pagemask}, ppage = tlb_paddr[31:12] & ~{4'h0,tlb_pagemask}, and rptr += 1 (wraps at ENTRIES-1 -> 0). Go to IDLE, ready=0.
- Miss latency: 2 cycles after acceptance.
- Exceptions are never cached; a retry re-walks.
- Flush clears all valid bits at the next edge.
- LOOKUP in a flush cycle is forced to miss.
- WALK in a flush cycle still responds but does not refill.
- rptr is not reset by flush.
- Reset: state=IDLE, all valid=0, rptr=0, vreg=0. resp_valid=0, resp_* = 0, ready=1 after reset release.
- Reset mid-walk aborts with no response.
- Outputs resp_* are 0 when resp_valid=0.

Optional Feature:
- MICRO_ITLB_STATS_EN
  - Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Saturating counters that increment on LOOKUP hit and LOOKUP miss respectively, reset to 0 by rst, unaffected by flush.
  - Undefined: ports and logic absent.

Decomposition:
- Shared package: state encoding (IDLE/LOOKUP/WALK), entry field widths (TAG_W=20, MASK_W=16, PPAGE_W=20), cache code UNCACHED=3'b010.
- One sub-module, micro_itlb_entry: holds one entry's registers and produces hit plus translated paddr for a given vaddr. Instantiated ENTRIES times; the top level holds the FSM, rptr, and priority select.

Test Plan:
- Cold miss: req vaddr=0x00401234; TLB returns paddr=0x01801234, pagemask=0, cache=3 -> resp 2 cycles later with paddr=0x01801234, cache=3; entry 0 filled.
- Repeat vaddr=0x00401ABC -> resp 1 cycle later, paddr=0x01801ABC, no tlb use (state never WALK); hits back-to-back at 1/cycle.
- Unmapped: vaddr=0x80001000, tlb_paddr=0x00001000, pagemask=16'hffff, then vaddr=0x8FFFF000 -> hit, paddr=0x0FFFF000.
- TLB exception: tlb_miss=1 -> resp_miss=1; re-request of the same vaddr walks again (no fill).
- Wrap: 5 distinct page misses with ENTRIES=4 -> the 5th overwrites entry 0; the first page then misses.
- Flush during WALK -> response delivered, no fill. Async rst low mid-LOOKUP -> no resp_valid, all entries invalid after release.
